// File: rtl/door_pkg.sv
// Shared constants and input indexing for the door input conditioning slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
`timescale 1ns/1ps
package door_pkg;

  localparam int CLK2M_HZ           = 2_000_000;
  localparam int DEB_CYCLES_DEFAULT = 20000;
  localparam int NUM_IN             = 4;

  // Bit positions of the conditioned inputs inside the packed raw/stable vectors.
  typedef enum logic [1:0] {
    IN_KEY_UP     = 2'd0,
    IN_KEY_DOWN   = 2'd1,
    IN_SENSE_UP   = 2'd2,
    IN_SENSE_DOWN = 2'd3
  } door_in_e;

endpackage

// File: rtl/debounce_cell_1596.sv
// Purpose: 2-FF synchroniser plus stability counter producing an accepted (debounced) level.
// Latency: a clean change on raw shows on stable at the (DEB_CYCLES+2)th rising edge.
// Backpressure: none; free-running on every clk2m edge.
`timescale 1ns/1ps
module debounce_cell_1596 #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int             CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser: raw is asynchronous to clk2m.
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Count consecutive cycles where the synchronised input disagrees with the accepted
  // level; any agreement (a bounce) restarts the count. The counter is cleared on
  // acceptance, so it never reaches DEB_CYCLES and cannot wrap.
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/door_input_cond_1596.sv
// Purpose: condition door pushbuttons/end sensors into key pulses and clean sensor levels.
// Latency: sensor level at edge DEB_CYCLES+2, key pulse at edge DEB_CYCLES+3 after a raw change.
// Backpressure: none. Optional macro DOOR_SENSE_FAULT_EN adds the sticky both-sensors fault.
`timescale 1ns/1ps
module door_input_cond_1596
  import door_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic key_up_raw,
  input  logic key_down_raw,
  input  logic sense_up_raw,
  input  logic sense_down_raw,
  output logic key_up,
  output logic key_down,
  output logic sense_up,
  output logic sense_down,
  output logic sense_fault
);

  logic [NUM_IN-1:0] raw_vec;
  logic [NUM_IN-1:0] stable_vec;
  logic              stable_up_d;
  logic              stable_down_d;
  logic              rise_up;
  logic              rise_down;
  logic              key_up_q;
  logic              key_down_q;

  assign raw_vec[IN_KEY_UP]     = key_up_raw;
  assign raw_vec[IN_KEY_DOWN]   = key_down_raw;
  assign raw_vec[IN_SENSE_UP]   = sense_up_raw;
  assign raw_vec[IN_SENSE_DOWN] = sense_down_raw;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
    debounce_cell_1596 #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk2m  (clk2m),
      .rst_n  (rst_n),
      .raw    (raw_vec[g]),
      .stable (stable_vec[g])
    );
  end

  // Rising edges of the accepted key levels; a simultaneous rise of both keys is
  // ambiguous to the door FSM, so it is dropped entirely.
  assign rise_up   = stable_vec[IN_KEY_UP]   & ~stable_up_d;
  assign rise_down = stable_vec[IN_KEY_DOWN] & ~stable_down_d;

  // Delayed key levels and one-cycle press pulses; both reset low so reset
  // release never produces a pulse.
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      stable_up_d   <= 1'b0;
      stable_down_d <= 1'b0;
      key_up_q      <= 1'b0;
      key_down_q    <= 1'b0;
    end else begin
      stable_up_d   <= stable_vec[IN_KEY_UP];
      stable_down_d <= stable_vec[IN_KEY_DOWN];
      key_up_q      <= rise_up   & ~rise_down;
      key_down_q    <= rise_down & ~rise_up;
    end
  end

`ifdef DOOR_SENSE_FAULT_EN
  logic fault_q;

  // Both end positions active at once is physically impossible: latch the fault
  // until reset and silence everything the FSM would act on.
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (stable_vec[IN_SENSE_UP] & stable_vec[IN_SENSE_DOWN]) begin
      fault_q <= 1'b1;
    end
  end

  assign sense_fault = fault_q;
  assign key_up      = key_up_q   & ~fault_q;
  assign key_down    = key_down_q & ~fault_q;
  assign sense_up    = stable_vec[IN_SENSE_UP]   & ~fault_q;
  assign sense_down  = stable_vec[IN_SENSE_DOWN] & ~fault_q;
`else
  // The fault port stays for fixed wiring to the FSM but carries no logic.
  assign sense_fault = 1'b0;
  assign key_up      = key_up_q;
  assign key_down    = key_down_q;
  assign sense_up    = stable_vec[IN_SENSE_UP];
  assign sense_down  = stable_vec[IN_SENSE_DOWN];
`endif

endmodule
